// File: rtl/alu_fsm_param.sv
// Parametrised FSM-controlled ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic/shift ops plus an iterative shift-add unsigned multiply.
module alu_fsm_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic [SHW-1:0]     shAmt;
  logic [WIDTH:0]     addW, subW, sllW, srlW, sraW, mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH-1:0]   aluRes;
  logic               aluC, aluV, aluErr;

  assign shAmt = b_q[SHW-1:0];
  assign addW  = {1'b0, a_q} + {1'b0, b_q};
  assign subW  = {1'b0, a_q} - {1'b0, b_q};
  // One extra bit beyond the operand catches the last bit shifted out
  assign sllW  = {1'b0, a_q} << shAmt;
  assign srlW  = {a_q, 1'b0} >> shAmt;
  assign sraW  = $signed({a_q, 1'b0}) >>> shAmt;

  // Shift-add step: low half starts as the multiplier and is consumed LSB first
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    aluErr = 1'b0;
    case (op_q)
      OP_ADD: begin
        aluRes = addW[WIDTH-1:0];
        aluC   = addW[WIDTH];
        aluV   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (addW[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = subW[WIDTH-1:0];
        aluC   = subW[WIDTH];
        aluV   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (subW[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: aluRes = a_q & b_q;
      OP_OR:  aluRes = a_q | b_q;
      OP_XOR: aluRes = a_q ^ b_q;
      OP_SLL: begin
        aluRes = sllW[WIDTH-1:0];
        aluC   = sllW[WIDTH];
      end
      OP_SRL: begin
        aluRes = srlW[WIDTH:1];
        aluC   = srlW[0];
      end
      OP_SRA: begin
        aluRes = sraW[WIDTH:1];
        aluC   = sraW[0];
      end
      OP_MUL: aluErr = 1'b0;
      default: aluErr = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_MUL) begin
          acc_d   = {{WIDTH{1'b0}}, b_q};
          cnt_d   = '0;
          state_d = MUL;
        end else begin
          // Illegal opcodes leave aluRes at zero but must not raise the zero flag
          res_d   = aluRes;
          hi_d    = '0;
          z_d     = !aluErr && (aluRes == '0);
          n_d     = aluRes[WIDTH-1];
          c_d     = aluC;
          v_d     = aluV;
          err_d   = aluErr;
          state_d = DONE;
        end
      end
      MUL: begin
        acc_d = mulNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          res_d   = mulNext[WIDTH-1:0];
          hi_d    = mulNext[2*WIDTH-1:WIDTH];
          z_d     = (mulNext[WIDTH-1:0] == '0);
          n_d     = mulNext[WIDTH-1];
          c_d     = (mulNext[2*WIDTH-1:WIDTH] != '0);
          v_d     = (mulNext[2*WIDTH-1:WIDTH] != '0);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign err       = err_q;

endmodule

// File: doc/alu_fsm_param.md
Name: alu_fsm_param

Overview:
Parametrised successor to the 4-bit FSM-controlled ALU. The operand width is set by a parameter. Both sides use valid/ready handshakes, and the output side supports backpressure. Adds shift ops, an iterative multi-cycle unsigned multiply, status flags (zero/negative/carry/overflow) and an illegal-opcode error flag. Sits between an operand-issuing controller and a result consumer on a single clock domain.

Parameters:
WIDTH, 8, operand/result width in bits; legal values 4..32, power of two.
SHW, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand bundle valid
in_ready  out  1  block can accept operands
opcode  in  4  operation select, sampled at input handshake
a  in  WIDTH  operand A
b  in  WIDTH  operand B; shift amount = b[SHW-1:0]
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result, low half for MUL
result_hi  out  WIDTH  MUL high half; 0 for all other ops
flag_z  out  1  result == 0 (low half only)
flag_n  out  1  result[WIDTH-1]
flag_c  out  1  carry/borrow/shift-out/MUL-high-nonzero
flag_v  out  1  signed overflow / MUL-high-nonzero
err  out  1  illegal opcode

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; in_ready=1; out_valid=0; result, result_hi, all flags and err = 0. An assertion mid-operation aborts immediately; the in-flight op is discarded with no output.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (unsigned). 9..15 are illegal: result=0, result_hi=0, flags=0, err=1.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge, a/b/opcode are captured into internal registers and the FSM goes to EXEC. Inputs are ignored in all other states.
- EXEC (1 cycle): non-MUL ops register result and flags and go to DONE. MUL loads the accumulator and counter and goes to MUL.
- MUL: one shift-add step per cycle, exactly WIDTH cycles, then register result/result_hi/flags and go to DONE.
- DONE: out_valid=1. Stays in DONE until out_ready is sampled high. That edge goes to IDLE with out_valid=0.
- Latency:
  - Non-MUL: out_valid rises 2 edges after the accepting edge.
  - MUL: out_valid rises 2+WIDTH edges after the accepting edge.
  - Next accept is possible no earlier than the edge after the output handshake.
- result, result_hi, flags and err change only on entry to DONE. They hold through IDLE until the next result, and stay stable while out_valid=1 and out_ready=0.
- err is 0 for any legal op.
- Arithmetic: all operations are modulo 2^WIDTH.
- ADD: c = carry-out; v = operands have the same sign and the result sign differs.
- SUB: c = borrow (a<b unsigned); v = operand signs differ and the result sign differs from a.
- AND/OR/XOR: c=0, v=0.
- SLL/SRL/SRA: shift by b[SHW-1:0]; upper bits of b are ignored. c = last bit shifted out (0 if the amount is 0); v=0. SRA replicates a[WIDTH-1].
- MUL: {result_hi,result} = a*b, 2*WIDTH bits. c = v = (result_hi != 0).
- z and n are computed on result for every legal op.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 -> result=0x10, c=1, v=0, z=0, n=0, err=0; out_valid rises 2 edges after accept.
- SUB a=0x80 b=0x01 -> result=0x7F, v=1, c=0, n=0. SUB a=0x05 b=0x05 -> result=0x00, z=1, c=0.
- MUL a=0x10 b=0x20 -> result=0x00, result_hi=0x02, z=1, c=1, v=1; out_valid rises exactly 10 edges after accept; in_ready=0 throughout.
- SRA a=0x90 b=0x0B (amount 3) -> result=0xF2, c=0, n=1. SLL a=0x81 b=0x01 -> result=0x02, c=1.
- Backpressure: ADD 0x01+0x02, out_ready held 0 for 5 cycles with in_valid=1 and a new opcode -> result=0x03 stable, out_valid=1, in_ready=0, new bundle not captured. out_ready=1 -> out_valid falls next edge, in_ready=1.
- Opcode 0xC -> err=1, result=0, all flags 0. rst_n pulsed low mid-MUL -> outputs zero immediately, in_ready=1, no out_valid afterwards.
